yield_share_tracker: RTL and testbench
======================================

Name: yield_share_tracker

Overview:
- Sits directly downstream of trinity_v4_top and consumes its 32-bit cumulative mining_yield (uBTC).
- Converts the cumulative counter into discrete share events (delta, timestamp) buffered in a small FIFO with a valid/ready output.
- Maintains a running 48-bit total and a per-window yield rate for the telemetry/reporting stage.

Parameters:
- YIELD_W, 32, width of mining_yield and of event deltas
- TOTAL_W, 48, width of the running total accumulator
- WINDOW_CYCLES, 1024, rate-window length in clk cycles (≥2)
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- mining_yield  in  YIELD_W  cumulative yield from trinity_v4_top
- sample_en  in  1  capture mining_yield this cycle
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid=1
- evt_delta  out  YIELD_W  yield increment of head event
- evt_stamp  out  32  cycle-counter value at the sample edge of head event
- total_yield  out  TOTAL_W  sum of all accepted deltas
- window_rate  out  YIELD_W  sum of deltas in the last completed window (saturating)
- overflow_cnt  out  16  events dropped on full FIFO (saturates at 0xFFFF)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- regress_flag  out  1  sticky regression flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; FIFO empty; cycle counter 0; window counter 0; state PRIME.
- Reset asserted mid-operation: flushes the FIFO and all counters on that edge, discarding any in-flight event.
- Cycle counter: 32-bit free-running, increments every non-reset cycle, wraps modulo 2^32.
- State PRIME:
  - The first edge with sample_en=1 stores mining_yield as the baseline.
  - Emits no event.
  - Moves to RUN.
- State RUN, capture: an edge E with sample_en=1 registers cur=mining_yield and stamp=cycle counter.
- State RUN, edge E+1:
  - delta = cur − last, computed modulo 2^YIELD_W; last <= cur.
  - If delta ≠ 0, the event is pushed, total_yield += delta (wraps modulo 2^TOTAL_W), and delta is added to the window accumulator.
  - If delta = 0, no event.
- Latency: with an empty FIFO, evt_valid is high in the cycle after edge E+1.
- Back-to-back sample_en: supported, one result per cycle.
- FIFO full at the push edge:
  - Event dropped; overflow_cnt +1.
  - total_yield and the window accumulator still update.
- FIFO full with a simultaneous push and pop (evt_valid & evt_ready): both happen, level unchanged, no drop.
- Pop: happens on any edge with evt_valid & evt_ready. evt_delta and evt_stamp always reflect the head; they hold while evt_valid=1 and evt_ready=0.
- Window:
  - The counter runs 0..WINDOW_CYCLES−1.
  - On the wrap edge, window_rate <= accumulator + any delta accepted on that same edge, saturating at 2^YIELD_W−1, and the accumulator clears.
  - The accumulator saturates at 2^YIELD_W−1.
- Without the optional feature: a non-zero mining_yield decrease is a valid modular increment, and regress_flag is tied 0.

Optional Feature:
- Macro: YIELD_MONOTONIC_CHECK_EN.
- Defined: a delta whose MSB is set (the counter went backwards) is a regression:
  - No event, no total or window update.
  - The baseline is rebased to cur.
  - regress_flag is set and stays set until rst.
- Undefined: all non-zero deltas are accepted modulo 2^YIELD_W, and regress_flag is constant 0.

Decomposition:
- Package trinity_yield_pkg holds:
  - YIELD_W and TOTAL_W defaults.
  - The typedef yield_evt_t {delta, stamp}.
  - The state enum {PRIME, RUN}.
  - The 16-bit counter saturation constant.
- Sub-module yield_evt_fifo: a synchronous FIFO of yield_evt_t with push/pop/full/empty/level, instantiated once.

Test Plan:
- Reset, then sample_en with mining_yield=100 → no event; after the next sample at 150 → evt_delta=50, evt_valid two edges after the capture edge, total_yield=50.
- Ten sample_en pulses while evt_ready=0 and each delta is non-zero, FIFO_DEPTH=8 → fifo_level=8, overflow_cnt=2; then drain with evt_ready=1 → 8 events in order, stamps strictly increasing.
- FIFO full, with evt_ready=1 and a new non-zero delta pushed on the same edge → level stays 8, overflow_cnt unchanged.
- mining_yield goes 0xFFFF_FFF0 → 0x0000_0010 with the macro undefined → evt_delta=0x20. With YIELD_MONOTONIC_CHECK_EN, the drop 500 → 400 gives no event, regress_flag=1, and a following 410 gives delta=10.
- Deltas of 7 and 5 inside window 0, plus a delta of 3 accepted on the wrap edge → window_rate=15, and the next window starts from 0.
- rst asserted for one cycle with 3 events queued and a capture in flight → all outputs 0, state PRIME, and the next sample produces no event.

Source files
------------

// File: rtl/trinity_yield_pkg.sv
// rtl/trinity_yield_pkg.sv - shared widths, event record and state encoding for the yield share tracker
package trinity_yield_pkg;

  localparam int YIELD_W_DEF = 32;
  localparam int TOTAL_W_DEF = 48;
  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  typedef enum logic {PRIME, RUN} trk_state_e;

  typedef struct packed {
    logic [YIELD_W_DEF-1:0] delta;
    logic [31:0]            stamp;
  } yield_evt_t;

endpackage

// File: rtl/yield_evt_fifo.sv
// rtl/yield_evt_fifo.sv - synchronous event FIFO; a push into a full FIFO succeeds only alongside a pop
import trinity_yield_pkg::*;

module yield_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int EW    = $bits(yield_evt_t),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Head reads as zero when empty so stale storage never leaks after a flush.
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/yield_share_tracker.sv
// rtl/yield_share_tracker.sv - turns cumulative mining yield into share events, total and window rate
// Optional regression detection is enabled by defining YIELD_MONOTONIC_CHECK_EN.
import trinity_yield_pkg::*;

module yield_share_tracker #(
  parameter int YIELD_W       = YIELD_W_DEF,
  parameter int TOTAL_W       = TOTAL_W_DEF,
  parameter int WINDOW_CYCLES = 1024,
  parameter int FIFO_DEPTH    = 8,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1,
  localparam int WW           = $clog2(WINDOW_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [YIELD_W-1:0] mining_yield,
  input  logic               sample_en,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [YIELD_W-1:0] evt_delta,
  output logic [31:0]        evt_stamp,
  output logic [TOTAL_W-1:0] total_yield,
  output logic [YIELD_W-1:0] window_rate,
  output logic [15:0]        overflow_cnt,
  output logic [LW-1:0]      fifo_level,
  output logic               regress_flag
);

  trk_state_e         state_q;
  logic [31:0]        cyc_q, stamp_q;
  logic [WW-1:0]      win_q;
  logic [YIELD_W-1:0] last_q, cur_q, acc_q, rate_q;
  logic [TOTAL_W-1:0] total_q;
  logic [15:0]        ovf_q;
  logic               pend_q, regress_q;

  logic [YIELD_W-1:0] delta, acc_d;
  logic [YIELD_W:0]   acc_sum;
  logic               regress, accept, pop, full, empty, drop, win_wrap;
  yield_evt_t         evt_in, evt_out;

  assign delta = cur_q - last_q;
`ifdef YIELD_MONOTONIC_CHECK_EN
  assign regress = pend_q & delta[YIELD_W-1];
`else
  assign regress = 1'b0;
`endif
  assign accept   = pend_q & (delta != '0) & ~regress;
  assign pop      = evt_valid & evt_ready;
  assign drop     = accept & full & ~pop;
  assign win_wrap = (win_q == WW'(WINDOW_CYCLES - 1));

  // Saturating window sum, including any delta landing on the wrap edge itself.
  assign acc_sum = {1'b0, acc_q} + {1'b0, (accept ? delta : '0)};
  assign acc_d   = acc_sum[YIELD_W] ? '1 : acc_sum[YIELD_W-1:0];

  assign evt_in.delta = delta;
  assign evt_in.stamp = stamp_q;

  yield_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (evt_in),
    .dout  (evt_out),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRIME;
      cyc_q     <= '0;
      win_q     <= '0;
      last_q    <= '0;
      cur_q     <= '0;
      stamp_q   <= '0;
      pend_q    <= 1'b0;
      total_q   <= '0;
      acc_q     <= '0;
      rate_q    <= '0;
      ovf_q     <= '0;
      regress_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_q + 32'd1;
      win_q  <= win_wrap ? '0 : win_q + WW'(1);
      pend_q <= 1'b0;
      case (state_q)
        PRIME: if (sample_en) begin
          last_q  <= mining_yield;
          state_q <= RUN;
        end
        RUN: begin
          if (pend_q) last_q <= cur_q;
          if (sample_en) begin
            cur_q   <= mining_yield;
            stamp_q <= cyc_q;
            pend_q  <= 1'b1;
          end
        end
        default: state_q <= PRIME;
      endcase
      if (accept) total_q <= total_q + TOTAL_W'(delta);
      if (win_wrap) begin
        rate_q <= acc_d;
        acc_q  <= '0;
      end else begin
        acc_q  <= acc_d;
      end
      if (drop && ovf_q != CNT16_MAX) ovf_q <= ovf_q + 16'd1;
      if (regress) regress_q <= 1'b1;
    end
  end

  assign evt_valid    = ~empty;
  assign evt_delta    = evt_out.delta;
  assign evt_stamp    = evt_out.stamp;
  assign total_yield  = total_q;
  assign window_rate  = rate_q;
  assign overflow_cnt = ovf_q;
  assign regress_flag = regress_q;

endmodule

// File: tb/tb_yield_share_tracker.sv
// tb/tb_yield_share_tracker.sv - scoreboard bench for yield_share_tracker (either YIELD_MONOTONIC_CHECK_EN build)
module tb_yield_share_tracker;

  localparam int W = 64;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] s;
  } exp_t;

  logic        clk, rst, sample_en, evt_valid, evt_ready, regress_flag;
  logic [31:0] mining_yield, evt_delta, evt_stamp, window_rate;
  logic [47:0] total_yield;
  logic [15:0] overflow_cnt;
  logic [3:0]  fifo_level;

  int          total, bad;
  logic [31:0] tb_cyc, y_cur;
  logic [47:0] exp_total;
  exp_t        q[$];
  exp_t        e_mon;

  yield_share_tracker #(.WINDOW_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mining_yield (mining_yield),
    .sample_en    (sample_en),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_delta    (evt_delta),
    .evt_stamp    (evt_stamp),
    .total_yield  (total_yield),
    .window_rate  (window_rate),
    .overflow_cnt (overflow_cnt),
    .fifo_level   (fifo_level),
    .regress_flag (regress_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expected event.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_evt: actual delta=%0h stamp=%0h required=none", evt_delta, evt_stamp);
      end else begin
        e_mon = q.pop_front();
        check("evt_delta", 64'(evt_delta), 64'(e_mon.d));
        check("evt_stamp", 64'(evt_stamp), 64'(e_mon.s));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp(input logic [31:0] y, input bit exp_evt, input logic [31:0] d);
    mining_yield = y;
    sample_en    = 1'b1;
    if (exp_evt) q.push_back({d, tb_cyc});
    tick(1);
    sample_en = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int i = 0;
    while ((tb_cyc % W) != p && i < 3 * W) begin
      tick(1);
      i++;
    end
    check("window_phase_reached", 64'(tb_cyc % W), 64'(p));
  endtask

  initial begin
    total = 0; bad = 0; exp_total = '0;
    rst = 1'b1; sample_en = 1'b0; mining_yield = '0; evt_ready = 1'b0;
    tick(2);
    check("rst_evt_valid", 64'(evt_valid), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_total", 64'(total_yield), 64'd0);
    check("rst_overflow", 64'(overflow_cnt), 64'd0);
    check("rst_window_rate", 64'(window_rate), 64'd0);
    check("rst_regress", 64'(regress_flag), 64'd0);
    rst = 1'b0;

    // First sample is the baseline; next one yields delta 50 two edges after capture.
    smp(32'd100, 1'b0, 32'd0);
    tick(1);
    check("prime_no_evt", 64'(evt_valid), 64'd0);
    smp(32'd150, 1'b1, 32'd50);
    exp_total += 48'd50;
    check("latency_not_yet", 64'(evt_valid), 64'd0);
    tick(1);
    check("latency_valid", 64'(evt_valid), 64'd1);
    check("total_50", 64'(total_yield), 64'd50);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("first_pop_level", 64'(fifo_level), 64'd0);

    // Ten back-to-back samples into an 8-deep FIFO: two drops.
    y_cur = 32'd150;
    for (int i = 1; i <= 10; i++) begin
      y_cur += 32'(i);
      smp(y_cur, (i <= 8), 32'(i));
      exp_total += 48'(i);
    end
    tick(1);
    check("full_level", 64'(fifo_level), 64'd8);
    check("overflow_2", 64'(overflow_cnt), 64'd2);
    check("total_after_burst", 64'(total_yield), 64'd105);

    // Push and pop on the same edge while full: no drop, level holds.
    y_cur += 32'd100;
    smp(y_cur, 1'b1, 32'd100);
    exp_total += 48'd100;
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("full_pushpop_level", 64'(fifo_level), 64'd8);
    check("full_pushpop_overflow", 64'(overflow_cnt), 64'd2);
    evt_ready = 1'b1;
    tick(10);
    check("drain_level", 64'(fifo_level), 64'd0);
    check("drain_sb_empty", 64'(q.size()), 64'd0);
    check("total_205", 64'(total_yield), 64'(exp_total));

`ifndef YIELD_MONOTONIC_CHECK_EN
    smp(32'hFFFF_FFF0, 1'b1, 32'hFFFF_FEBF);
    exp_total += 48'h0_FFFF_FEBF;
    smp(32'h0000_0010, 1'b1, 32'h20);
    exp_total += 48'h20;
    y_cur = 32'h10;
    tick(2);
    check("wrap_total", 64'(total_yield), 64'h0000_FFFF_FFAC);
    check("regress_tied0", 64'(regress_flag), 64'd0);
`else
    smp(32'd500, 1'b1, 32'd195);
    exp_total += 48'd195;
    smp(32'd400, 1'b0, 32'd0);
    tick(1);
    check("regress_set", 64'(regress_flag), 64'd1);
    smp(32'd410, 1'b1, 32'd10);
    exp_total += 48'd10;
    y_cur = 32'd410;
    tick(2);
    check("regress_total", 64'(total_yield), 64'd410);
    check("regress_sticky", 64'(regress_flag), 64'd1);
`endif
    check("total_model", 64'(total_yield), 64'(exp_total));

    // Window: 7 and 5 inside the window, 3 accepted on the wrap edge.
    wait_phase(W / 2);
    wait_phase(1);
    y_cur += 32'd7;
    smp(y_cur, 1'b1, 32'd7);
    y_cur += 32'd5;
    smp(y_cur, 1'b1, 32'd5);
    wait_phase(W - 2);
    y_cur += 32'd3;
    smp(y_cur, 1'b1, 32'd3);
    tick(1);
    check("window_rate_15", 64'(window_rate), 64'd15);
    tick(1);
    wait_phase(0);
    check("window_rate_next_0", 64'(window_rate), 64'd0);

    // Reset with three events queued and a capture in flight.
    evt_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      y_cur += 32'd1;
      smp(y_cur, 1'b0, 32'd0);
    end
    y_cur += 32'd1;
    smp(y_cur, 1'b0, 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    q.delete();
    check("mid_rst_evt_valid", 64'(evt_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_total", 64'(total_yield), 64'd0);
    check("mid_rst_overflow", 64'(overflow_cnt), 64'd0);
    check("mid_rst_window_rate", 64'(window_rate), 64'd0);
    check("mid_rst_regress", 64'(regress_flag), 64'd0);
    check("mid_rst_delta", 64'(evt_delta), 64'd0);
    check("mid_rst_stamp", 64'(evt_stamp), 64'd0);
    smp(32'd1000, 1'b0, 32'd0);
    tick(2);
    check("post_rst_prime", 64'(evt_valid), 64'd0);
    smp(32'd1020, 1'b1, 32'd20);
    tick(1);
    check("post_rst_evt", 64'(evt_valid), 64'd1);
    evt_ready = 1'b1;
    tick(1);
    check("post_rst_level", 64'(fifo_level), 64'd0);
    check("post_rst_total", 64'(total_yield), 64'd20);
    check("final_sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
